uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART byte transmitter (tx_start/tx_busy byte interface) between N_REQ packet sources.
//  Round-robin grant per packet; each granted packet goes out as a header byte {HDR_SYNC, id} plus payload.
//  Sits between the flood/data producers and the single tx serializer on the 27 MHz domain.
// PARAMETERS
//  N_REQ      4     number of requesters, 2..8
//  ID_W       3     width of requester id field; N_REQ <= 2**ID_W
//  HDR_SYNC   5'h1A upper 8-ID_W bits of header byte
//  MAX_BYTES  16    max payload bytes per grant before forced release, 1..255
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous, active-low reset
//  req_valid  in   N_REQ      per-requester byte valid
//  req_data   in   8*N_REQ    per-requester byte; requester i on bits [8i+7:8i]
//  req_last   in   N_REQ      marks final payload byte of packet (qualified by valid)
//  req_ready  out  N_REQ      byte accepted this cycle (valid&ready = transfer)
//  tx_data    out  8          byte to serializer, stable while tx_start high
//  tx_start   out  1          one-cycle start pulse to serializer
//  tx_busy    in   1          serializer busy; high from cycle after tx_start until stop bit done
//  grant_id   out  ID_W       currently granted requester
//  active     out  1          a packet is in progress
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, rr_ptr=0, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, count=0.
//  FSM: IDLE -> HDR -> HDR_WAIT -> PAY -> PAY_WAIT -> (PAY | IDLE).
//  IDLE: if any req_valid, grant first valid at/after rr_ptr (wrap mod N_REQ); latch grant_id; active=1; -> HDR.
//   Requester with valid low is skipped; grant decided in 1 cycle; no valid -> stay IDLE.
//  HDR: when tx_busy=0, tx_start=1 for 1 cycle, tx_data={HDR_SYNC,grant_id}; -> HDR_WAIT.
//  HDR_WAIT / PAY_WAIT: ignore tx_busy in first cycle (serializer latency); then wait for tx_busy=0.
//   From HDR_WAIT -> PAY. From PAY_WAIT -> PAY, or IDLE if last byte sent / MAX_BYTES reached.
//  PAY: when req_valid[grant_id] and tx_busy=0: req_ready[grant_id]=1 same cycle (combinational),
//   tx_start=1, tx_data=req_data[grant_id], count++; latch sent_last=req_last[grant_id]; -> PAY_WAIT.
//   Valid low in PAY: wait indefinitely, grant held (no timeout). req_ready of non-granted ids always 0.
//  Release (-> IDLE): when sent_last=1 or count==MAX_BYTES; rr_ptr=grant_id+1 (wrap to 0 at N_REQ-1);
//   active=0, count=0. Forced release mid-packet: next grant of same id restarts with new header.
//  Latency: valid in IDLE -> header tx_start 2 cycles later if tx_busy=0.
//  At most one tx_start per frame; tx_start never asserted while tx_busy=1.
//  Byte order per packet: header, then payload in transfer order; never interleaved across ids.
//  Simultaneous requests: strict round-robin from rr_ptr; a requester with data is served within N_REQ grants.
//  Reset mid-packet: all outputs to reset values immediately; in-flight serializer frame not aborted here.
//  count width = clog2(MAX_BYTES+1); compare ==MAX_BYTES, no wrap possible.
// STRUCTURE
//  Shared package/header: state encodings (IDLE..PAY_WAIT), HDR_SYNC default, header-byte pack macro.
//  One sub-module: rr_arbiter (N_REQ req vector + ptr -> grant id, found flag), purely combinational.
//  Top holds FSM, counter, rr_ptr, output registers; tx serializer instantiated outside.
// TESTING (bench: this block + tx serializer + rx_module loopback, 27 MHz clk, $display of received bytes)
//  1. Req0 sends 3 bytes 0x11,0x22,0x33(last) -> rx gets 0xD0,0x11,0x22,0x33; active falls after last.
//  2. Req1,2,3 valid together, 1-byte packets, rr_ptr=0 -> headers in order id1,id2,id3 (0xD1,0xD2,0xD3).
//  3. Req2 streams 20 bytes, no last, MAX_BYTES=16 -> 0xD2+16 bytes, release, other reqs served, then 0xD2+4.
//  4. Req0 drops valid for 50 cycles mid-packet while req1 valid -> grant stays 0, no tx_start, req1 ready=0.
//  5. Hold tx_busy=1 externally 100 cycles in HDR -> no tx_start until release; no byte lost or duplicated.
//  6. Assert rst=0 during PAY_WAIT -> outputs zero asynchronously; after release next packet starts with header.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, header sync default, header packing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        HDR_WAIT = 3'd2,
        PAY      = 3'd3,
        PAY_WAIT = 3'd4
    } state_t;

    // Upper header bits for the default 3-bit requester id field.
    localparam logic [4:0] HDR_SYNC_DEFAULT = 5'h1A;

    // Header byte = {sync, id}; the id occupies the low id_w bits.
    function automatic logic [7:0] hdr_pack(input logic [7:0] sync, input logic [7:0] id, input int id_w);
        return (sync << id_w) | id;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is asserted.
module uart_tx_arbiter_rr #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             found
);

    logic [2*N_REQ-1:0] rotated;

    // Rotate the request vector so bit 0 is the requester at ptr, then take the first set bit.
    always_comb begin
        rotated = {req, req} >> ptr;
        grant   = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                grant = ID_W'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between N_REQ packet sources; round-robin grant per packet, header byte first.
// Latency: header tx_start 2 cycles after a request is seen in IDLE (tx_busy low); payload byte launches the cycle after accept.
// Backpressure: req_ready only for the granted source when the serializer is free; grant held while its valid is low.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int              N_REQ     = 4,
    parameter int              ID_W      = 3,
    parameter logic [7-ID_W:0] HDR_SYNC  = HDR_SYNC_DEFAULT,
    parameter int              MAX_BYTES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               active
);

    localparam int NSLOT = 1 << ID_W;
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    count;
    logic                sent_last;

    // Request vectors padded to the full id space so grant_id indexes them directly.
    logic [NSLOT-1:0]    valid_pad;
    logic [NSLOT-1:0]    last_pad;
    logic [8*NSLOT-1:0]  data_pad;
    logic [NSLOT-1:0]    ready_pad;
    logic                cur_valid;
    logic                cur_last;
    logic [7:0]          cur_data;

    logic [ID_W-1:0]     arb_grant;
    logic                arb_found;
    logic                grant_load;
    logic                fire_hdr;
    logic                fire_pay;
    logic                release_pkt;
    logic                frame_done;
    logic                release_due;

    uart_tx_arbiter_rr #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .found (arb_found)
    );

    // Zero-extend the per-requester inputs into the padded id space.
    always_comb begin
        valid_pad                = '0;
        last_pad                 = '0;
        data_pad                 = '0;
        valid_pad[N_REQ-1:0]     = req_valid;
        last_pad[N_REQ-1:0]      = req_last;
        data_pad[8*N_REQ-1:0]    = req_data;
    end

    assign cur_valid   = valid_pad[grant_id];
    assign cur_last    = last_pad[grant_id];
    assign cur_data    = data_pad[{grant_id, 3'b000} +: 8];
    assign req_ready   = ready_pad[N_REQ-1:0];
    assign release_due = sent_last || (count == CNT_W'(MAX_BYTES));
    // tx_start is high exactly in the first wait cycle, before the serializer can raise busy,
    // so it doubles as the "ignore tx_busy this cycle" marker.
    assign frame_done  = !tx_start && !tx_busy;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (arb_found)              state_nxt = HDR;
            HDR:      if (!tx_busy)               state_nxt = HDR_WAIT;
            HDR_WAIT: if (frame_done)             state_nxt = PAY;
            PAY:      if (cur_valid && !tx_busy)  state_nxt = PAY_WAIT;
            PAY_WAIT: if (frame_done)             state_nxt = release_due ? IDLE : PAY;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Per-state strobes, including the combinational accept for the granted source.
    always_comb begin
        grant_load  = 1'b0;
        fire_hdr    = 1'b0;
        fire_pay    = 1'b0;
        release_pkt = 1'b0;
        ready_pad   = '0;
        case (state)
            IDLE:     grant_load = arb_found;
            HDR:      fire_hdr   = !tx_busy;
            PAY: begin
                fire_pay            = cur_valid && !tx_busy;
                ready_pad[grant_id] = cur_valid && !tx_busy;
            end
            PAY_WAIT: release_pkt = frame_done && release_due;
            default:  ;
        endcase
    end

    // Output registers, grant/pointer bookkeeping and payload counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
            rr_ptr    <= '0;
            count     <= '0;
            sent_last <= 1'b0;
        end else begin
            tx_start <= fire_hdr || fire_pay;
            if (fire_hdr) begin
                tx_data <= hdr_pack(8'(HDR_SYNC), 8'(grant_id), ID_W);
            end else if (fire_pay) begin
                tx_data <= cur_data;
            end
            if (grant_load) begin
                grant_id  <= arb_grant;
                active    <= 1'b1;
                sent_last <= 1'b0;
            end
            if (fire_pay) begin
                count     <= count + 1'b1;
                sent_last <= cur_last;
            end
            if (release_pkt) begin
                active <= 1'b0;
                count  <= '0;
                rr_ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed packets, serializer model, byte-stream scoreboard.
// Latency: n/a.
// Backpressure: serializer busy model plus an external busy override.
module tb_uart_tx_arbiter;

    localparam int N_REQ     = 4;
    localparam int MAX_BYTES = 16;
    localparam int FRAME     = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        active;

    logic        ext_busy;
    logic        ser_busy;
    int          ser_cnt;

    // Per-requester source queues and accepted-byte logs, entries are {last, byte}.
    logic [8:0]  src_q   [N_REQ][$];
    logic [8:0]  acc_log [N_REQ][$];
    logic [7:0]  exp_q[$];

    int          checks   = 0;
    int          failures = 0;
    bit          pkt_open = 1'b0;
    int          cur_id   = 0;
    int          pay_n    = 0;

    always #5 clk = ~clk;

    assign tx_busy = ser_busy | ext_busy;

    uart_tx_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serializer model: busy from the tx_start cycle for FRAME cycles; never aborted by arbiter reset.
    initial begin
        ser_cnt  = 0;
        ser_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ser_cnt > 0) ser_cnt--;
            if (tx_start === 1'b1) ser_cnt = FRAME;
            ser_busy = (ser_cnt != 0);
        end
    end

    // Source driver: present queue heads, log every handshake, pop after it happened.
    initial begin
        bit pend [N_REQ];
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                if (pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                pend[i] = 1'b0;
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            #1;
            if (req_ready !== 4'b0000) begin
                chk("ready_onehot_granted", 32'(req_ready), 32'(1) << grant_id);
                chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'h0);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pend[i] = 1'b1;
                    acc_log[i].push_back(src_q[i][0]);
                end
            end
        end
    end

    // Stream checker: every tx_start byte against the expected stream and the packet framing model.
    initial begin
        logic [8:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start === 1'b1) begin
                chk("start_while_busy", 32'(tx_busy), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx_byte: got %02h expected none", tx_data);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                if (!pkt_open) begin
                    chk("hdr_sync", 32'(tx_data[7:3]), 32'h1A);
                    pkt_open = 1'b1;
                    cur_id   = int'(tx_data[2:0]);
                    pay_n    = 0;
                end else begin
                    pay_n++;
                    if (acc_log[cur_id].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL payload_not_accepted: got %02h expected a byte accepted from id %0d", tx_data, cur_id);
                    end else begin
                        a = acc_log[cur_id].pop_front();
                        chk("payload_vs_accepted", 32'(tx_data), 32'(a[7:0]));
                        if (a[8] || pay_n == MAX_BYTES) pkt_open = 1'b0;
                    end
                    chk("payload_len_bound", 32'(pay_n <= MAX_BYTES), 32'h1);
                end
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && active === 1'b0 && tx_busy === 1'b0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drain_in_time"}, 32'(n < budget), 32'h1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_start;
        int bad_grant;
        int bad_ready;
        int bad_active;
        int n;

        rst      = 1'b0;
        ext_busy = 1'b0;

        // Reset state.
        wait_cycles(3);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(2);

        // T1: req0 three bytes; header at the second edge after valid.
        src_q[0].push_back({1'b0, 8'h11});
        src_q[0].push_back({1'b0, 8'h22});
        src_q[0].push_back({1'b1, 8'h33});
        exp_q.push_back(8'hD0); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("t1_no_start_at_grant", 32'(tx_start), 32'h0);
        chk("t1_active_at_grant", 32'(active), 32'h1);
        chk("t1_grant_id", 32'(grant_id), 32'h0);
        @(posedge clk);
        #1;
        chk("t1_hdr_start", 32'(tx_start), 32'h1);
        chk("t1_hdr_data", 32'(tx_data), 32'hD0);
        wait_drain("t1", 400);
        chk("t1_active_after", 32'(active), 32'h0);

        // T2: req1..3 together, one byte each; round-robin from id1.
        src_q[1].push_back({1'b1, 8'h41});
        src_q[2].push_back({1'b1, 8'h42});
        src_q[3].push_back({1'b1, 8'h43});
        exp_q.push_back(8'hD1); exp_q.push_back(8'h41);
        exp_q.push_back(8'hD2); exp_q.push_back(8'h42);
        exp_q.push_back(8'hD3); exp_q.push_back(8'h43);
        wait_drain("t2", 600);

        // T3: req2 streams 20 bytes; forced release after 16, others served, then a fresh header for the rest.
        for (int k = 0; k < 20; k++) src_q[2].push_back({(k == 19), 8'(8'h60 + k)});
        exp_q.push_back(8'hD2);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h60 + k));
        wait_cycles(5);
        chk("t3_grant_id", 32'(grant_id), 32'h2);
        src_q[0].push_back({1'b1, 8'h01});
        src_q[3].push_back({1'b1, 8'h03});
        exp_q.push_back(8'hD3); exp_q.push_back(8'h03);
        exp_q.push_back(8'hD0); exp_q.push_back(8'h01);
        exp_q.push_back(8'hD2);
        for (int k = 16; k < 20; k++) exp_q.push_back(8'(8'h60 + k));
        wait_drain("t3", 2000);

        // T4: req0 stalls mid-packet while req1 waits; grant must hold.
        src_q[0].push_back({1'b0, 8'h81});
        src_q[0].push_back({1'b0, 8'h82});
        src_q[1].push_back({1'b1, 8'h91});
        exp_q.push_back(8'hD0); exp_q.push_back(8'h81); exp_q.push_back(8'h82);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            wait_cycles(1);
            n++;
        end
        chk("t4_first_bytes_in_time", 32'(n < 400), 32'h1);
        wait_cycles(15);
        bad_start = 0; bad_grant = 0; bad_ready = 0; bad_active = 0;
        for (int c = 0; c < 50; c++) begin
            wait_cycles(1);
            if (tx_start !== 1'b0) bad_start++;
            if (grant_id !== 3'd0) bad_grant++;
            if (req_ready[1] !== 1'b0) bad_ready++;
            if (active !== 1'b1) bad_active++;
        end
        chk("t4_stall_no_start", 32'(bad_start), 32'h0);
        chk("t4_stall_grant_held", 32'(bad_grant), 32'h0);
        chk("t4_stall_req1_not_ready", 32'(bad_ready), 32'h0);
        chk("t4_stall_active", 32'(bad_active), 32'h0);
        src_q[0].push_back({1'b1, 8'h83});
        exp_q.push_back(8'h83);
        exp_q.push_back(8'hD1); exp_q.push_back(8'h91);
        wait_drain("t4", 600);

        // T5: external busy held during the header wait.
        ext_busy = 1'b1;
        src_q[3].push_back({1'b0, 8'hA1});
        src_q[3].push_back({1'b1, 8'hA2});
        exp_q.push_back(8'hD3); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        bad_start = 0;
        for (int c = 0; c < 100; c++) begin
            wait_cycles(1);
            if (tx_start !== 1'b0) bad_start++;
        end
        chk("t5_busy_no_start", 32'(bad_start), 32'h0);
        chk("t5_busy_grant_id", 32'(grant_id), 32'h3);
        chk("t5_busy_active", 32'(active), 32'h1);
        chk("t5_busy_hdr_pending", 32'(exp_q.size()), 32'h3);
        ext_busy = 1'b0;
        wait_drain("t5", 600);

        // T6: reset while the first payload frame is in flight.
        src_q[1].push_back({1'b0, 8'hB1});
        src_q[1].push_back({1'b0, 8'hB2});
        src_q[1].push_back({1'b1, 8'hB3});
        exp_q.push_back(8'hD1); exp_q.push_back(8'hB1);
        n = 0;
        while (!(tx_start === 1'b1 && tx_data === 8'hB1) && n < 400) begin
            wait_cycles(1);
            n++;
        end
        chk("t6_reached_pay_wait", 32'(n < 400), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_tx_start", 32'(tx_start), 32'h0);
        chk("t6_rst_tx_data", 32'(tx_data), 32'h0);
        chk("t6_rst_grant_id", 32'(grant_id), 32'h0);
        chk("t6_rst_active", 32'(active), 32'h0);
        chk("t6_rst_req_ready", 32'(req_ready), 32'h0);
        exp_q.delete();
        for (int i = 0; i < N_REQ; i++) begin
            src_q[i].delete();
            acc_log[i].delete();
        end
        pkt_open = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        rst = 1'b1;
        src_q[1].push_back({1'b1, 8'hC1});
        exp_q.push_back(8'hD1); exp_q.push_back(8'hC1);
        wait_drain("t6", 600);

        n = 0;
        for (int i = 0; i < N_REQ; i++) n += src_q[i].size() + acc_log[i].size();
        chk("all_sources_drained", 32'(n), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
